msk_gf2n_mul_hpc3_pipe: RTL and testbench
=========================================

Name: msk_gf2n_mul_hpc3_pipe

Overview:
- d-share HPC3 masked multiplier over GF(2^W), polynomial basis, reduction polynomial POLY.
- Generalises the fixed G(4) HPC3 multiplier in three ways: parametric field width, an internally registered copy of operand a (no external a_prev ports), and a valid/ready pipeline stage with stall.
- Sits in masked S-box / datapath pipelines, one register stage deep.
- PINI; security holds under stall because all registers are enable-gated together.

Parameters:
- d, `DEFAULTSHARES (2): number of shares, must be ≥2.
- W, 4: field width in bits, 2..8.
- POLY, 'h13: reduction polynomial, W+1 bits, bit W set (x^4+x+1 by default).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand sharings valid.
- in_ready  out  1  stage can accept.
- in_a  in  d*W  sharing of a; share i at [i*W +: W].
- in_b  in  d*W  sharing of b; same packing.
- rnd  in  d*(d-1)*W  fresh randomness, sampled only on accept.
- out_valid  out  1  product sharing valid.
- out_ready  in  1  downstream accepts.
- out_c  out  d*W  sharing of c = a·b; same packing.

Behaviour:
- Randomness unpacking:
  - For each pair i<j, p = i*d - i*(i+1)/2 + (j-1-i).
  - R0[i,j] = R0[j,i] = rnd[2pW +: W].
  - R1[i,j] = R1[j,i] = rnd[(2p+1)W +: W].
- Handshake:
  - accept = in_valid & in_ready.
  - in_ready = !out_valid | out_ready (combinational, no registered skid).
- On accept, for every i≠j, with j2 = (j<i ? j : j-1):
  - U[i][j2] <= a_i·(b_i ⊕ R0) ⊕ R1 if j2==0, otherwise a_i·R0 ⊕ R1.
  - V[i][j2] <= b_j ⊕ R0.
  - A[i] <= a_i.
  - out_valid <= 1.
- Otherwise:
  - If out_ready, out_valid <= 0.
  - All data registers hold.
- Output (combinational from registers): out_c share i = XOR over j2 of U[i][j2] ⊕ (A[i]·V[i][j2]).
  - Recombination is correct: XOR of all output shares = a·b.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 per cycle when out_ready is held high.
- Simultaneous output consume and new accept in the same cycle: out_valid stays 1 and data is replaced.
- Stall (out_valid & !out_ready):
  - in_ready = 0.
  - in_a, in_b and rnd are ignored.
  - out_c is held stable.
- GF multiply:
  - Shift-and-add over W bits; reduce by POLY.
  - Purely combinational, no carry/overflow beyond W bits.
- Reset (rst_n low at a clk edge):
  - out_valid = 0.
  - U, V and A cleared to 0, so out_c = 0.
  - Reset has priority over accept.
  - Any in-flight result is dropped.
  - in_ready = 1 from the first cycle after reset.
- Randomness must not be combined with inputs before the register except as listed above; no glitch path from rnd to out_c.

Test Plan:
- d=2, W=4, POLY=13. a shares (5,6)=3, b shares (A,D)=7, rnd=0, accept → next cycle out_valid=1 and out_c0⊕out_c1 = 9.
- Same operands with random rnd over 1000 cycles, out_ready=1 → every output XOR = 9. Individual shares vary with rnd; one result per cycle.
- d=3, W=4: a=F, b=F, arbitrary sharings → XOR of out_c = A. Also a=8, b=2 → 3; a=0 → 0.
- d=2, W=8, POLY=11B: a=57, b=83 → C1.
- Stall: accept, then out_ready=0 for 5 cycles while in_a/in_b/rnd toggle → in_ready=0, out_c constant. Raising out_ready with in_valid=1 in the same cycle → old result consumed and new one valid the next cycle.
- Reset mid-operation: accept, then rst_n=0 one cycle → out_valid=0, out_c=0, in_ready=1. Reset asserted with in_valid=1 → nothing captured.

Source files
------------

// File: rtl/msk_gf2n_mul_hpc3_pipe_if.sv
// Stream bundle for the masked GF(2^W) multiplier: operand/randomness input side and
// product-sharing output side, each with its own valid/ready pair.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

interface msk_gf2n_mul_hpc3_pipe_if #(
  parameter int unsigned d = `DEFAULTSHARES,
  parameter int unsigned W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [d*W-1:0]           in_a;
  logic [d*W-1:0]           in_b;
  logic [d*(d-1)*W-1:0]     rnd;
  logic                     out_valid;
  logic                     out_ready;
  logic [d*W-1:0]           out_c;

  modport master (
    output in_valid, in_a, in_b, rnd, out_ready,
    input  in_ready, out_valid, out_c
  );

  modport slave (
    input  in_valid, in_a, in_b, rnd, out_ready,
    output in_ready, out_valid, out_c
  );
endinterface

// File: rtl/msk_gf2n_mul_hpc3_pipe.sv
// d-share HPC3 masked multiplier over GF(2^W) with one valid/ready register stage.
// All state shares a single enable, so a stall never mixes shares of different inputs.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_gf2n_mul_hpc3_pipe #(
  parameter int unsigned d    = `DEFAULTSHARES,
  parameter int unsigned W    = 4,
  parameter logic [W:0]  POLY = 'h13
) (
  input logic                     clk,
  input logic                     rst_n,
  msk_gf2n_mul_hpc3_pipe_if.slave bus
);

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] acc;
    logic [W-1:0] sh;
    acc = '0;
    sh  = x;
    for (int unsigned k = 0; k < W; k++) begin
      if (y[k]) acc = acc ^ sh;
      sh = {sh[W-2:0], 1'b0} ^ (sh[W-1] ? POLY[W-1:0] : '0);
    end
    return acc;
  endfunction

  logic [W-1:0] a_sh [d];
  logic [W-1:0] b_sh [d];
  logic [W-1:0] u_d  [d][d-1];
  logic [W-1:0] v_d  [d][d-1];
  logic [W-1:0] u_q  [d][d-1];
  logic [W-1:0] v_q  [d][d-1];
  logic [W-1:0] a_q  [d];
  logic         valid_q;
  logic         accept;
  logic [d*W-1:0] c_d;

  for (genvar i = 0; i < d; i++) begin : g_unpack
    assign a_sh[i] = bus.in_a[i*W +: W];
    assign b_sh[i] = bus.in_b[i*W +: W];
  end

  // Each unordered pair (lo, hi) owns two randomness words, shared by both directions.
  for (genvar i = 0; i < d; i++) begin : g_row
    for (genvar j = 0; j < d; j++) begin : g_col
      if (j != i) begin : g_pair
        localparam int unsigned J2 = (j < i) ? j : j - 1;
        localparam int unsigned Lo = (i < j) ? i : j;
        localparam int unsigned Hi = (i < j) ? j : i;
        localparam int unsigned P  = Lo * d - Lo * (Lo + 1) / 2 + (Hi - 1 - Lo);
        logic [W-1:0] r0;
        logic [W-1:0] r1;
        assign r0 = bus.rnd[2*P*W +: W];
        assign r1 = bus.rnd[(2*P+1)*W +: W];
        if (J2 == 0) begin : g_first
          // First cross term also carries the a_i*b_i self product.
          assign u_d[i][J2] = gf_mul(a_sh[i], b_sh[i] ^ r0) ^ r1;
        end else begin : g_rest
          assign u_d[i][J2] = gf_mul(a_sh[i], r0) ^ r1;
        end
        assign v_d[i][J2] = b_sh[j] ^ r0;
      end
    end
  end

  assign bus.in_ready = !valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < d; i++) begin
        a_q[i] <= '0;
        for (int unsigned j = 0; j < d - 1; j++) begin
          u_q[i][j] <= '0;
          v_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      valid_q <= 1'b1;
      for (int unsigned i = 0; i < d; i++) begin
        a_q[i] <= a_sh[i];
        for (int unsigned j = 0; j < d - 1; j++) begin
          u_q[i][j] <= u_d[i][j];
          v_q[i][j] <= v_d[i][j];
        end
      end
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Second half of the product is formed only from registered values.
  always_comb begin
    c_d = '0;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = 0; j < d - 1; j++) begin
        c_d[i*W +: W] = c_d[i*W +: W] ^ u_q[i][j] ^ gf_mul(a_q[i], v_q[i][j]);
      end
    end
  end

  assign bus.out_c     = c_d;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_msk_gf2n_mul_hpc3_pipe.sv
// Scoreboard bench for the masked multiplier: d=2/W=4, d=3/W=4 and d=2/W=8 instances
// driven from one clock; products recombined from the output shares.
module tb_msk_gf2n_mul_hpc3_pipe;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];
  logic [7:0] sb2 [$];

  msk_gf2n_mul_hpc3_pipe_if #(.d(2), .W(4)) bus0 ();
  msk_gf2n_mul_hpc3_pipe_if #(.d(3), .W(4)) bus1 ();
  msk_gf2n_mul_hpc3_pipe_if #(.d(2), .W(8)) bus2 ();

  msk_gf2n_mul_hpc3_pipe #(.d(2), .W(4), .POLY(5'h13)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );
  msk_gf2n_mul_hpc3_pipe #(.d(3), .W(4), .POLY(5'h13)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );
  msk_gf2n_mul_hpc3_pipe #(.d(2), .W(8), .POLY(9'h11B)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full carry-less product, then reduce from the top bit down.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                         input int w, input logic [8:0] poly);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < w; k++) if (y[k]) p = p ^ (16'(x) << k);
    for (int k = 2 * w - 2; k >= w; k--) if (p[k]) p = p ^ (16'(poly) << (k - w));
    return p[7:0];
  endfunction

  function automatic logic [23:0] mk_share(input logic [7:0] v, input int nd, input int w);
    logic [23:0] s;
    logic [7:0]  m;
    logic [7:0]  acc;
    logic [7:0]  r;
    m   = 8'hFF >> (8 - w);
    s   = '0;
    acc = v & m;
    for (int i = 0; i < nd - 1; i++) begin
      r   = 8'($urandom) & m;
      s   = s | (24'(r) << (i * w));
      acc = acc ^ r;
    end
    s = s | (24'(acc) << ((nd - 1) * w));
    return s;
  endfunction

  function automatic logic [7:0] unshare(input logic [23:0] c, input int nd, input int w);
    logic [7:0] m;
    logic [7:0] acc;
    m   = 8'hFF >> (8 - w);
    acc = '0;
    for (int i = 0; i < nd; i++) acc = acc ^ (8'(c >> (i * w)) & m);
    return acc;
  endfunction

  task automatic test_reset();
    rst_n          = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_a      = 8'h65;
    bus0.in_b      = 8'hDA;
    bus0.rnd       = 8'hA5;
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.rnd       = '0;
    bus1.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_a      = '0;
    bus2.in_b      = '0;
    bus2.rnd       = '0;
    bus2.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_in_reset: got %b expected 0", bus0.out_valid);
    end
    checks++;
    if (bus0.out_c !== 8'h00) begin
      errors++;
      $display("FAIL reset_outc_in_reset: got %h expected 00", bus0.out_c);
    end
    rst_n         = 1'b1;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0 || bus2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b%b%b expected 000",
               bus0.out_valid, bus1.out_valid, bus2.out_valid);
    end
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", bus0.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    @(negedge clk);
    bus0.in_a     = 8'h65;
    bus0.in_b     = 8'hDA;
    bus0.rnd      = 8'h00;
    bus0.in_valid = 1'b1;
    sb0.push_back(ref_mul(8'h3, 8'h7, 4, 9'h13));
    @(negedge clk);
    bus0.in_valid = 1'b0;
    checks++;
    if (bus0.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid got %b expected 1", bus0.out_valid);
    end
    exp = sb0.pop_front();
    checks++;
    if (unshare(24'(bus0.out_c), 2, 4) !== exp) begin
      errors++;
      $display("FAIL basic_model: got %h expected %h", unshare(24'(bus0.out_c), 2, 4), exp);
    end
    checks++;
    if (unshare(24'(bus0.out_c), 2, 4) !== 8'h09) begin
      errors++;
      $display("FAIL basic_xor: got %h expected 09", unshare(24'(bus0.out_c), 2, 4));
    end
    // With zero randomness share 0 is a0*(b0^b1).
    checks++;
    if (bus0.out_c[3:0] !== ref_mul(8'h5, 8'h7, 4, 9'h13)) begin
      errors++;
      $display("FAIL basic_share0: got %h expected %h", bus0.out_c[3:0],
               ref_mul(8'h5, 8'h7, 4, 9'h13));
    end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: out_valid got %b expected 0", bus0.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] s;
    logic [7:0]  exp;
    logic [3:0]  prev0;
    int          changes;
    changes        = 0;
    prev0          = '0;
    bus0.out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (n > 0) begin
        checks++;
        if (bus0.out_valid !== 1'b1 || sb0.size() == 0) begin
          errors++;
          $display("FAIL tput_valid: cycle %0d out_valid %b queued %0d", n, bus0.out_valid,
                   sb0.size());
        end else begin
          exp = sb0.pop_front();
          checks++;
          if (unshare(24'(bus0.out_c), 2, 4) !== exp) begin
            errors++;
            $display("FAIL tput_xor: cycle %0d got %h expected %h", n,
                     unshare(24'(bus0.out_c), 2, 4), exp);
          end
          if (n > 1 && bus0.out_c[3:0] !== prev0) changes++;
          prev0 = bus0.out_c[3:0];
        end
      end
      s = mk_share(8'h3, 2, 4);
      bus0.in_a = s[7:0];
      s = mk_share(8'h7, 2, 4);
      bus0.in_b     = s[7:0];
      bus0.rnd      = 8'($urandom);
      bus0.in_valid = 1'b1;
      sb0.push_back(ref_mul(8'h3, 8'h7, 4, 9'h13));
    end
    @(negedge clk);
    bus0.in_valid = 1'b0;
    checks++;
    if (bus0.out_valid !== 1'b1 || sb0.size() != 1) begin
      errors++;
      $display("FAIL tput_last: out_valid %b queued %0d expected 1 and 1", bus0.out_valid,
               sb0.size());
    end else begin
      exp = sb0.pop_front();
      checks++;
      if (unshare(24'(bus0.out_c), 2, 4) !== exp) begin
        errors++;
        $display("FAIL tput_last_xor: got %h expected %h", unshare(24'(bus0.out_c), 2, 4), exp);
      end
    end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tput_drain: out_valid got %b expected 0", bus0.out_valid);
    end
    checks++;
    if (changes < 100) begin
      errors++;
      $display("FAIL tput_share_variation: got %0d changes expected at least 100", changes);
    end
  endtask

  task automatic test_stall();
    logic [23:0] s;
    logic [7:0]  snap;
    logic [7:0]  exp;
    @(negedge clk);
    s = mk_share(8'hB, 2, 4);
    bus0.in_a = s[7:0];
    s = mk_share(8'h4, 2, 4);
    bus0.in_b      = s[7:0];
    bus0.rnd       = 8'($urandom);
    bus0.in_valid  = 1'b1;
    bus0.out_ready = 1'b1;
    sb0.push_back(ref_mul(8'hB, 8'h4, 4, 9'h13));
    @(negedge clk);
    snap           = bus0.out_c;
    bus0.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      bus0.in_a = 8'($urandom);
      bus0.in_b = 8'($urandom);
      bus0.rnd  = 8'($urandom);
      @(negedge clk);
      checks++;
      if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hs: cycle %0d in_ready %b out_valid %b expected 0 and 1", n,
                 bus0.in_ready, bus0.out_valid);
      end
      checks++;
      if (bus0.out_c !== snap) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got %h expected %h", n, bus0.out_c, snap);
      end
      checks++;
      if (unshare(24'(bus0.out_c), 2, 4) !== sb0[0]) begin
        errors++;
        $display("FAIL stall_xor: cycle %0d got %h expected %h", n,
                 unshare(24'(bus0.out_c), 2, 4), sb0[0]);
      end
    end
    // Release: old result consumed and new operands accepted on the same edge.
    bus0.out_ready = 1'b1;
    s = mk_share(8'h8, 2, 4);
    bus0.in_a = s[7:0];
    s = mk_share(8'h2, 2, 4);
    bus0.in_b = s[7:0];
    bus0.rnd  = 8'($urandom);
    void'(sb0.pop_front());
    sb0.push_back(ref_mul(8'h8, 8'h2, 4, 9'h13));
    @(negedge clk);
    bus0.in_valid = 1'b0;
    exp = sb0.pop_front();
    checks++;
    if (bus0.out_valid !== 1'b1 || unshare(24'(bus0.out_c), 2, 4) !== exp) begin
      errors++;
      $display("FAIL stall_release: out_valid %b got %h expected 1 and %h", bus0.out_valid,
               unshare(24'(bus0.out_c), 2, 4), exp);
    end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: out_valid got %b expected 0", bus0.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] s;
    @(negedge clk);
    s = mk_share(8'hC, 2, 4);
    bus0.in_a = s[7:0];
    s = mk_share(8'h5, 2, 4);
    bus0.in_b     = s[7:0];
    bus0.rnd      = 8'($urandom);
    bus0.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_accept: out_valid got %b expected 1", bus0.out_valid);
    end
    rst_n          = 1'b0;
    bus0.out_ready = 1'b0;
    bus0.in_a      = 8'h9F;
    bus0.in_b      = 8'h3C;
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.out_c !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_clear: out_valid %b out_c %h expected 0 and 00", bus0.out_valid,
               bus0.out_c);
    end
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b expected 1", bus0.in_ready);
    end
    rst_n          = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nocapture: out_valid got %b expected 0", bus0.out_valid);
    end
  endtask

  task automatic test_d3();
    logic [7:0]  ta [6];
    logic [7:0]  tb [6];
    logic [7:0]  te [6];
    logic [23:0] s;
    logic [7:0]  exp;
    ta = '{8'hF, 8'h8, 8'h0, 8'h0, 8'h0, 8'h0};
    tb = '{8'hF, 8'h2, 8'h0, 8'h0, 8'h0, 8'h0};
    te = '{8'hA, 8'h3, 8'h0, 8'h0, 8'h0, 8'h0};
    tb[2] = 8'($urandom_range(15, 1));
    for (int k = 3; k < 6; k++) begin
      ta[k] = 8'($urandom_range(15, 0));
      tb[k] = 8'($urandom_range(15, 0));
      te[k] = ref_mul(ta[k], tb[k], 4, 9'h13);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s = mk_share(ta[k], 3, 4);
      bus1.in_a = s[11:0];
      s = mk_share(tb[k], 3, 4);
      bus1.in_b     = s[11:0];
      bus1.rnd      = 24'($urandom);
      bus1.in_valid = 1'b1;
      sb1.push_back(te[k]);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      exp = sb1.pop_front();
      checks++;
      if (bus1.out_valid !== 1'b1 || unshare(24'(bus1.out_c), 3, 4) !== exp) begin
        errors++;
        $display("FAIL d3_mul: a=%h b=%h valid %b got %h expected %h", ta[k], tb[k],
                 bus1.out_valid, unshare(24'(bus1.out_c), 3, 4), exp);
      end
    end
  endtask

  task automatic test_w8();
    logic [7:0]  ta [4];
    logic [7:0]  tb [4];
    logic [7:0]  te [4];
    logic [23:0] s;
    logic [7:0]  exp;
    ta[0] = 8'h57;
    tb[0] = 8'h83;
    te[0] = 8'hC1;
    for (int k = 1; k < 4; k++) begin
      ta[k] = 8'($urandom);
      tb[k] = 8'($urandom);
      te[k] = ref_mul(ta[k], tb[k], 8, 9'h11B);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s = mk_share(ta[k], 2, 8);
      bus2.in_a = s[15:0];
      s = mk_share(tb[k], 2, 8);
      bus2.in_b     = s[15:0];
      bus2.rnd      = 16'($urandom);
      bus2.in_valid = 1'b1;
      sb2.push_back(te[k]);
      @(negedge clk);
      bus2.in_valid = 1'b0;
      exp = sb2.pop_front();
      checks++;
      if (bus2.out_valid !== 1'b1 || unshare(24'(bus2.out_c), 2, 8) !== exp) begin
        errors++;
        $display("FAIL w8_mul: a=%h b=%h valid %b got %h expected %h", ta[k], tb[k],
                 bus2.out_valid, unshare(24'(bus2.out_c), 2, 8), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_d3();
    test_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
